memory_game_ctrl: RTL and testbench
===================================

// Module: memory_game_ctrl
// PURPOSE
//  Parametrised single-clock controller for the memory game: generates a pseudo-random cell
//  sequence, shows it one cell per tick, checks player presses, and keeps level/score/combo/lives.
//  Replaces the divided-clock level-chooser + game-brain pair with one tick-enabled FSM.
//  Sits between button debouncers and the display/7-seg drivers.
// PARAMETERS
//  CELL_W      2        bits per cell id; board has 2**CELL_W cells
//  NUM_LEVELS  4        number of levels; level output saturates at NUM_LEVELS-1
//  BASE_LEN    3        sequence length at level 0
//  LEN_STEP    1        extra elements per level
//  MAX_LEN     16       hard cap on sequence length
//  LIVES       3        lives at game start
//  TICK_DIV    50000000 clk cycles per display/timeout tick (>=2)
//  TIMEOUT_TK  10       ticks without a press in INPUT -> fail
//  POINTS      10       base points per cleared round
//  SCORE_W     12       score width; COMBO_W 8 combo width
//  LFSR_SEED   16'hACE1 LFSR value after reset
// PORTS
//  clk         in   1        system clock
//  reset       in   1        synchronous, active-low reset
//  en          in   1        1 = run; 0 = freeze all state, ignore inputs
//  start       in   1        1-cycle pulse: start/restart game (IDLE or OVER only)
//  btn_valid   in   1        1-cycle pulse: player pressed btn_cell
//  btn_cell    in   CELL_W   pressed cell id
//  disp        out  1        1 = disp_cell is being shown
//  disp_cell   out  CELL_W   cell currently shown
//  level       out  $clog2(NUM_LEVELS)  current level, 0-based
//  score       out  SCORE_W  saturating score
//  combo       out  COMBO_W  consecutive cleared rounds, saturating
//  life        out  $clog2(LIVES+1)     remaining lives
//  state       out  3        FSM state encoding (debug/LEDs)
//  round_ok    out  1        1-cycle pulse on round cleared
//  round_fail  out  1        1-cycle pulse on round failed
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, level=0, score=0, combo=0, life=LIVES, disp=0,
//   disp_cell=0, pulses=0, lfsr=seed=LFSR_SEED, tick counter=0. Overrides everything, incl. mid-round.
//  en==0: no register changes (tick counter frozen, buttons/start ignored). Outputs hold.
//  tick: 1-cycle strobe when counter hits TICK_DIV-1, then counter wraps to 0.
//  len = min(BASE_LEN + level*LEN_STEP, MAX_LEN). Element = lfsr[CELL_W-1:0]; lfsr advances per element.
//  Sequence is not stored: seed latched at round start; lfsr<=seed on every replay/check start.
//  States: IDLE, SHOW_ON, SHOW_OFF, INPUT, WIN, FAIL, OVER.
//   IDLE: start -> level=0,score=0,combo=0,life=LIVES, lfsr<=seed, idx=0 -> SHOW_OFF.
//   SHOW_OFF: disp=0; on tick -> SHOW_ON, disp_cell<=element.
//   SHOW_ON: disp=1 for exactly one tick; on tick: advance lfsr, idx++;
//    idx==len-1 -> INPUT (lfsr<=seed, idx=0, timeout=0) else SHOW_OFF.
//   INPUT: btn_valid & btn_cell==element -> advance lfsr, idx++, timeout=0; last element -> WIN.
//    btn_valid & mismatch -> FAIL. Timeout reaches TIMEOUT_TK ticks -> FAIL.
//    btn_valid and timeout-expiry same cycle: button wins.
//   WIN (1 cycle): round_ok=1; score += (level+1)*POINTS + combo, saturate at 2**SCORE_W-1;
//    combo++ saturating; level++ saturating; seed<=lfsr (fresh sequence); idx=0 -> SHOW_OFF.
//   FAIL (1 cycle): round_fail=1; combo=0; life--; life now 0 -> OVER,
//    else lfsr<=seed (same sequence replayed), idx=0 -> SHOW_OFF.
//   OVER: outputs hold final score/level, life=0; start -> same as IDLE start (seed kept from lfsr).
//  start outside IDLE/OVER ignored. btn_valid outside INPUT ignored. Presses during show dropped.
//  Sum for score computed at SCORE_W+1 bits before saturation; no wrap anywhere.
// STRUCTURE
//  Package memgame_pkg: state_t enum (3-bit, encodings = state output), LFSR_TAPS constant
//   (16-bit Fibonacci x^16+x^14+x^13+x^11+1), helper function lfsr_next().
//  Sub-module tick_gen #(TICK_DIV) (clk, reset, en, tick): free-running enabled divider.
//  Everything else (FSM, lfsr, counters, scoring) in memory_game_ctrl.
// TESTING (TICK_DIV=4, BASE_LEN=3, LEN_STEP=1, LIVES=3, POINTS=10, TIMEOUT_TK=10)
//  1 Reset mid-SHOW_ON -> next cycle state=IDLE, disp=0, life=3, score=0, lfsr=16'hACE1.
//  2 start, watch disp -> 3 pulses, each high 4 cycles, 4-cycle gaps; cells match model LFSR.
//  3 Replay shown 3 cells -> round_ok 1 cycle, score=10, combo=1, level=1; next show has 4 cells.
//  4 Wrong 2nd press -> round_fail, life=2, combo=0, same 3 cells replayed; 3 fails -> OVER, life=0.
//  5 No press for 40 cycles in INPUT -> FAIL; press on the expiry cycle -> accepted, no FAIL.
//  6 en=0 for 100 cycles mid-show -> all outputs frozen, resumes identically; start in INPUT ignored.

Source files
------------

// File: rtl/memgame_pkg.sv
// Shared types and LFSR helper for the memory game controller.
// State encodings double as the debug/LED state output.
package memgame_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SHOW_ON  = 3'd1,
      S_SHOW_OFF = 3'd2,
      S_INPUT    = 3'd3,
      S_WIN      = 3'd4,
      S_FAIL     = 3'd5,
      S_OVER     = 3'd6
   } state_t;

   // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form:
   // feedback bit is the XOR of bits 0,2,3,5, shifted in at bit 15.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {^(cur & LFSR_TAPS), cur[15:1]};
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running enabled divider: one-cycle tick every TICK_DIV clocks.
// Counter and strobe both freeze while en_i is low.
module tick_gen #(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int unsigned CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Strobe on the last count, then wrap
   always_comb begin
      tick_o = en_i && (cnt_q == LAST);
      cnt_d  = cnt_q;
      if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // Divider register
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/memory_game_ctrl.sv
// Memory game controller: LFSR-generated sequence shown one cell per
// tick, player replay checking, and level/score/combo/lives keeping.
module memory_game_ctrl
   import memgame_pkg::*;
#(
   parameter int unsigned CELL_W     = 2,
   parameter int unsigned NUM_LEVELS = 4,
   parameter int unsigned BASE_LEN   = 3,
   parameter int unsigned LEN_STEP   = 1,
   parameter int unsigned MAX_LEN    = 16,
   parameter int unsigned LIVES      = 3,
   parameter int unsigned TICK_DIV   = 50000000,
   parameter int unsigned TIMEOUT_TK = 10,
   parameter int unsigned POINTS     = 10,
   parameter int unsigned SCORE_W    = 12,
   parameter int unsigned COMBO_W    = 8,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic                           en_i,
   input  logic                           start_i,
   input  logic                           btn_valid_i,
   input  logic [CELL_W-1:0]              btn_cell_i,
   output logic                           disp_o,
   output logic [CELL_W-1:0]              disp_cell_o,
   output logic [$clog2(NUM_LEVELS)-1:0]  level_o,
   output logic [SCORE_W-1:0]             score_o,
   output logic [COMBO_W-1:0]             combo_o,
   output logic [$clog2(LIVES+1)-1:0]     life_o,
   output logic [2:0]                     state_o,
   output logic                           round_ok_o,
   output logic                           round_fail_o
);

   localparam int unsigned LVL_W     = $clog2(NUM_LEVELS);
   localparam int unsigned LIFE_W    = $clog2(LIVES + 1);
   localparam int unsigned IDX_W     = $clog2(MAX_LEN + 1);
   localparam int unsigned TO_W      = $clog2(TIMEOUT_TK + 1);
   localparam int unsigned SUM_W     = SCORE_W + 1;
   localparam int unsigned SCORE_MAX = (2 ** SCORE_W) - 1;

   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_TK - 1);
   localparam logic [LVL_W-1:0]  LVL_TOP   = LVL_W'(NUM_LEVELS - 1);
   localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(LIVES);

   state_t             state_q, state_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [15:0]        seed_q, seed_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [TO_W-1:0]    to_q, to_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [COMBO_W-1:0] combo_q, combo_d;
   logic [LIFE_W-1:0]  life_q, life_d;
   logic [CELL_W-1:0]  cell_q, cell_d;

   logic               tick;
   logic [CELL_W-1:0]  elem;
   logic [IDX_W-1:0]   last_idx;
   logic               is_last;
   logic [31:0]        len_w;
   logic [31:0]        bonus_w;
   logic [SUM_W-1:0]   sum_w;
   logic               sum_sat;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (en_i),
      .tick_o  (tick)
   );

   assign elem = lfsr_q[CELL_W-1:0];

   // Round length from level, and the saturating score increment
   always_comb begin
      len_w = BASE_LEN + 32'(level_q) * LEN_STEP;
      if (len_w > MAX_LEN) begin
         len_w = MAX_LEN;
      end
      last_idx = IDX_W'(len_w - 1);
      is_last  = (idx_q == last_idx);
      bonus_w  = (32'(level_q) + 1) * POINTS + 32'(combo_q);
      sum_w    = {1'b0, score_q} + SUM_W'(bonus_w);
      sum_sat  = sum_w[SCORE_W] || (bonus_w > SCORE_MAX);
   end

   // Next-state and datapath updates for the game FSM
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      seed_d  = seed_q;
      idx_d   = idx_q;
      to_d    = to_q;
      level_d = level_q;
      score_d = score_q;
      combo_d = combo_q;
      life_d  = life_q;
      cell_d  = cell_q;
      unique case (state_q)
         S_IDLE, S_OVER: begin
            if (start_i) begin
               level_d = '0;
               score_d = '0;
               combo_d = '0;
               life_d  = LIFE_INIT;
               seed_d  = lfsr_q;
               idx_d   = '0;
               state_d = S_SHOW_OFF;
            end
         end
         S_SHOW_OFF: begin
            if (tick) begin
               cell_d  = elem;
               state_d = S_SHOW_ON;
            end
         end
         S_SHOW_ON: begin
            if (tick) begin
               if (is_last) begin
                  lfsr_d  = seed_q;
                  idx_d   = '0;
                  to_d    = '0;
                  state_d = S_INPUT;
               end else begin
                  lfsr_d  = lfsr_next(lfsr_q);
                  idx_d   = idx_q + 1'b1;
                  state_d = S_SHOW_OFF;
               end
            end
         end
         S_INPUT: begin
            if (btn_valid_i) begin
               if (btn_cell_i == elem) begin
                  lfsr_d = lfsr_next(lfsr_q);
                  idx_d  = idx_q + 1'b1;
                  to_d   = '0;
                  if (is_last) begin
                     state_d = S_WIN;
                  end
               end else begin
                  state_d = S_FAIL;
               end
            end else if (tick) begin
               if (to_q == TO_LAST) begin
                  state_d = S_FAIL;
               end else begin
                  to_d = to_q + 1'b1;
               end
            end
         end
         S_WIN: begin
            score_d = sum_sat ? SCORE_W'(SCORE_MAX)
                              : sum_w[SCORE_W-1:0];
            if (combo_q != '1) begin
               combo_d = combo_q + 1'b1;
            end
            if (level_q != LVL_TOP) begin
               level_d = level_q + 1'b1;
            end
            seed_d  = lfsr_q;
            idx_d   = '0;
            state_d = S_SHOW_OFF;
         end
         S_FAIL: begin
            combo_d = '0;
            life_d  = life_q - 1'b1;
            if (life_q == LIFE_W'(1)) begin
               state_d = S_OVER;
            end else begin
               lfsr_d  = seed_q;
               idx_d   = '0;
               state_d = S_SHOW_OFF;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Game registers; en_i low holds every bit
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= S_IDLE;
         lfsr_q  <= LFSR_SEED;
         seed_q  <= LFSR_SEED;
         idx_q   <= '0;
         to_q    <= '0;
         level_q <= '0;
         score_q <= '0;
         combo_q <= '0;
         life_q  <= LIFE_INIT;
         cell_q  <= '0;
      end else if (en_i) begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         seed_q  <= seed_d;
         idx_q   <= idx_d;
         to_q    <= to_d;
         level_q <= level_d;
         score_q <= score_d;
         combo_q <= combo_d;
         life_q  <= life_d;
         cell_q  <= cell_d;
      end
   end

   assign disp_o       = (state_q == S_SHOW_ON);
   assign disp_cell_o  = cell_q;
   assign level_o      = level_q;
   assign score_o      = score_q;
   assign combo_o      = combo_q;
   assign life_o       = life_q;
   assign state_o      = state_q;
   assign round_ok_o   = (state_q == S_WIN);
   assign round_fail_o = (state_q == S_FAIL);

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Self-checking bench for memory_game_ctrl: scripted round table,
// hand-written corner sequences and random rounds against a game model.
module tb_memory_game_ctrl;

   localparam int A_OK    = 0;
   localparam int A_LATE  = 1;
   localparam int A_WRONG = 2;
   localparam int A_TMO   = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        start;
   logic        btn_valid;
   logic [1:0]  btn_cell;
   logic        disp;
   logic [1:0]  disp_cell;
   logic [1:0]  level;
   logic [11:0] score;
   logic [7:0]  combo;
   logic [1:0]  life;
   logic [2:0]  state;
   logic        round_ok;
   logic        round_fail;

   int vec = 0;
   int err = 0;

   logic [15:0] m_cur;
   logic [15:0] m_seed;
   int          m_level, m_score, m_combo, m_life;
   bit          m_over;

   typedef struct {
      int act;
      int k;
      bit frz;
      int score;
      int combo;
      int level;
      int life;
      int st;
   } row_t;

   row_t tbl[7];

   memory_game_ctrl #(
      .TICK_DIV   (4),
      .BASE_LEN   (3),
      .LEN_STEP   (1),
      .LIVES      (3),
      .POINTS     (10),
      .TIMEOUT_TK (10)
   ) dut (
      .clk_i        (clk),
      .reset_i      (rst_n),
      .en_i         (en),
      .start_i      (start),
      .btn_valid_i  (btn_valid),
      .btn_cell_i   (btn_cell),
      .disp_o       (disp),
      .disp_cell_o  (disp_cell),
      .level_o      (level),
      .score_o      (score),
      .combo_o      (combo),
      .life_o       (life),
      .state_o      (state),
      .round_ok_o   (round_ok),
      .round_fail_o (round_fail)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] ref_step(input logic [15:0] x);
      logic [15:0] b;
      b = ((x >> 0) ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 16'd1;
      return (x >> 1) | (b << 15);
   endfunction

   function automatic int m_len();
      return (3 + m_level > 16) ? 16 : 3 + m_level;
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      vec++;
      if (got !== exp) begin
         err++;
         $display("FAIL %s: got %0d, want %0d", name, got, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input int sc, input int cb,
                           input int lv, input int lf, input int st);
      chk({tag, "_score"}, 32'(score), 32'(sc));
      chk({tag, "_combo"}, 32'(combo), 32'(cb));
      chk({tag, "_level"}, 32'(level), 32'(lv));
      chk({tag, "_life"},  32'(life),  32'(lf));
      chk({tag, "_state"}, 32'(state), 32'(st));
   endtask

   task automatic model_start();
      m_seed  = m_cur;
      m_level = 0;
      m_score = 0;
      m_combo = 0;
      m_life  = 3;
      m_over  = 0;
   endtask

   task automatic model_win();
      int s;
      s = m_score + (m_level + 1) * 10 + m_combo;
      m_score = (s > 4095) ? 4095 : s;
      m_combo = (m_combo >= 255) ? 255 : m_combo + 1;
      m_level = (m_level >= 3) ? 3 : m_level + 1;
      m_seed  = m_cur;
   endtask

   task automatic model_fail();
      m_combo = 0;
      m_life  = m_life - 1;
      if (m_life == 0) m_over = 1;
      else m_cur = m_seed;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_start();
      chk("start_state", 32'(state), 32'd2);
   endtask

   task automatic press(input logic [1:0] c);
      btn_cell  = c;
      btn_valid = 1'b1;
      @(negedge clk);
      btn_valid = 1'b0;
   endtask

   task automatic build_seq(output logic [1:0] s[$]);
      logic [15:0] x;
      s = {};
      x = m_seed;
      for (int i = 0; i < m_len(); i++) begin
         s.push_back(x[1:0]);
         x = ref_step(x);
      end
   endtask

   task automatic show_phase(input bit frz, output bit ok);
      logic [1:0] s[$];
      logic [1:0] got[$];
      bit prev, frozen;
      int hi, gap, cyc, n;
      build_seq(s);
      prev = 0; frozen = 0; hi = 0; gap = 0; cyc = 0; ok = 0;
      while (cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (disp && !prev) begin
            if (got.size() > 0) chk("show_gap", 32'(gap), 32'd4);
            got.push_back(disp_cell);
            hi = 0;
         end
         if (!disp && prev) begin
            chk("show_high", 32'(hi), 32'd4);
            gap = 0;
         end
         if (disp) hi++;
         else gap++;
         prev = disp;
         if (state == 3'd3) begin
            ok = 1;
            break;
         end
         if (frz && !frozen && got.size() == 2 && hi == 2) begin
            frozen = 1;
            en = 1'b0;
            repeat (100) begin
               @(negedge clk);
               start     = 1'($urandom % 2);
               btn_valid = 1'($urandom % 2);
               btn_cell  = 2'($urandom);
            end
            start = 1'b0;
            btn_valid = 1'b0;
            chk("frz_disp", 32'(disp), 32'd1);
            chk("frz_cell", 32'(disp_cell), 32'(s[1]));
            chk_outs("frz", m_score, m_combo, m_level, m_life, 1);
            en = 1'b1;
         end
         btn_valid = ($urandom % 5 == 0);
         btn_cell  = 2'($urandom);
      end
      btn_valid = 1'b0;
      if (!ok) begin
         vec++;
         err++;
         $display("FAIL show_budget: got no INPUT, want INPUT in 400 cycles");
      end
      chk("show_count", 32'(got.size()), 32'(s.size()));
      n = (got.size() < s.size()) ? got.size() : s.size();
      for (int i = 0; i < n; i++) chk("show_cell", 32'(got[i]), 32'(s[i]));
   endtask

   task automatic play_round(input int act, input int k, input bit frz);
      logic [1:0] s[$];
      bit ok;
      int first, cnt;
      show_phase(frz, ok);
      if (!ok) return;
      build_seq(s);
      first = 0;
      if (act == A_OK) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("start_ignored", 32'(state), 32'd3);
      end
      if (act == A_LATE) begin
         repeat (39) @(negedge clk);
         press(s[0]);
         m_cur = ref_step(m_cur);
         chk("late_state", 32'(state), 32'd3);
         chk("late_nofail", 32'(round_fail), 32'd0);
         first = 1;
      end
      if (act == A_OK || act == A_LATE) begin
         for (int i = first; i < s.size(); i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            press(s[i]);
            m_cur = ref_step(m_cur);
         end
         chk("win_state", 32'(state), 32'd4);
         chk("round_ok", 32'(round_ok), 32'd1);
         @(negedge clk);
         chk("round_ok_clr", 32'(round_ok), 32'd0);
         model_win();
      end else begin
         for (int i = 0; i < k; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            press(s[i]);
            m_cur = ref_step(m_cur);
         end
         if (act == A_WRONG) begin
            press(2'(s[k] ^ 2'b01));
         end else begin
            cnt = 0;
            while (state != 3'd5 && cnt < 60) begin
               @(negedge clk);
               cnt++;
            end
            if (k == 0) chk("timeout_cycles", 32'(cnt), 32'd40);
         end
         chk("fail_state", 32'(state), 32'd5);
         chk("round_fail", 32'(round_fail), 32'd1);
         @(negedge clk);
         chk("round_fail_clr", 32'(round_fail), 32'd0);
         model_fail();
      end
   endtask

   initial begin
      bit ok;
      int act, k;
      tbl[0] = '{A_WRONG, 1, 1'b0,   0, 0, 0, 2, 2};
      tbl[1] = '{A_OK,    0, 1'b1,  10, 1, 1, 2, 2};
      tbl[2] = '{A_LATE,  0, 1'b0,  31, 2, 2, 2, 2};
      tbl[3] = '{A_TMO,   0, 1'b0,  31, 0, 2, 1, 2};
      tbl[4] = '{A_OK,    0, 1'b0,  61, 1, 3, 1, 2};
      tbl[5] = '{A_OK,    0, 1'b0, 102, 2, 3, 1, 2};
      tbl[6] = '{A_WRONG, 0, 1'b0, 102, 0, 3, 0, 6};

      rst_n = 1'b0;
      en = 1'b1;
      start = 1'b0;
      btn_valid = 1'b0;
      btn_cell = 2'd0;
      repeat (3) @(negedge clk);
      chk_outs("rst", 0, 0, 0, 3, 0);
      chk("rst_disp", 32'(disp), 32'd0);
      chk("rst_cell", 32'(disp_cell), 32'd0);
      chk("rst_ok", 32'(round_ok), 32'd0);
      chk("rst_fail", 32'(round_fail), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // one won round, then reset in the middle of the next show
      m_cur = 16'hACE1;
      do_start();
      play_round(A_OK, 0, 1'b0);
      chk_outs("r0", m_score, m_combo, m_level, m_life, 2);
      k = 0;
      while (!disp && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("pre_rst_disp", 32'(disp), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_outs("midrst", 0, 0, 0, 3, 0);
      chk("midrst_disp", 32'(disp), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // scripted game from the reset seed
      m_cur = 16'hACE1;
      do_start();
      for (int r = 0; r < 7; r++) begin
         play_round(tbl[r].act, tbl[r].k, tbl[r].frz);
         chk_outs($sformatf("tbl%0d", r), tbl[r].score, tbl[r].combo,
                  tbl[r].level, tbl[r].life, tbl[r].st);
      end

      // random rounds against the model
      for (int r = 0; r < 30; r++) begin
         if (m_over) do_start();
         act = int'($urandom_range(0, 3));
         k = int'($urandom_range(0, m_len() - 1));
         play_round(act, k, 1'b0);
         chk_outs($sformatf("rnd%0d", r), m_score, m_combo, m_level,
                  m_life, m_over ? 6 : 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
